// File: rtl/radix_complement_pkg.sv
// Shared types and op encodings for the digit-serial add/sub/negate unit.
package radix_complement_pkg;

    localparam logic [1:0] OpAddCode = 2'b00;
    localparam logic [1:0] OpSubCode = 2'b01;
    localparam logic [1:0] OpNegCode = 2'b10;

    typedef enum logic [1:0] {
        OpAdd = OpAddCode,
        OpSub = OpSubCode,
        OpNeg = OpNegCode
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/radix_digit_adder.sv
// Combinational W-bit slice adder; also reports the carry into the slice MSB.
module radix_digit_adder #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        // Carry into bit W-1 recovered from that bit's sum and operands.
        cmsb = sum[W-1] ^ a[W-1] ^ b[W-1];
    end

endmodule

// File: rtl/radix_complement_addsub.sv
// Digit-serial two's complement ADD/SUB/NEG, one W-bit slice per cycle.
// Optional saturation on overflow: define RADIX_COMPLEMENT_ADDSUB_SATURATE_EN.
module radix_complement_addsub
    import radix_complement_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         carry_out,
    output logic         overflow,
    output logic         negative,
    output logic         zero
);

    localparam int unsigned WSafe = (W == 0) ? 1 : W;
    localparam int unsigned S     = N / WSafe;
    localparam int unsigned CW    = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(S - 1);

    if (W == 0 || W > N || (N % WSafe) != 0) begin : g_bad_cfg
        $error("radix_complement_addsub: W must divide N and not exceed it");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  result_q, result_d;
    logic          carry_out_q, carry_out_d;
    logic          overflow_q, overflow_d;
    logic          negative_q, negative_d;
    logic          zero_q, zero_d;

    logic [W-1:0]  slice_sum;
    logic          slice_cout, slice_cmsb;
    logic [N-1:0]  full_sum, sat_sum;
    logic          ovf;

    radix_digit_adder #(
        .W (W)
    ) u_digit_adder (
        .a    (opa_q[W-1:0]),
        .b    (opb_q[W-1:0]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // Accumulator shifts right each slice, so after S slices it holds the full word.
    assign full_sum = (acc_q >> W) | (N'(slice_sum) << (N - W));
    // For NEG (~a + 1) this equals a == 2^(N-1).
    assign ovf      = slice_cmsb ^ slice_cout;

`ifdef RADIX_COMPLEMENT_ADDSUB_SATURATE_EN
    localparam logic [N-1:0] MinNeg = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MaxPos = ~MinNeg;

    logic sign_q, sign_d;

    assign sat_sum = ovf ? (sign_q ? MinNeg : MaxPos) : full_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else begin
            sign_q <= sign_d;
        end
    end

    always_comb begin
        sign_d = sign_q;
        if (state_q == StIdle && in_valid) begin
            sign_d = (op == OpNegCode) ? 1'b0 : a[N-1];
        end
    end
`else
    assign sat_sum = full_sum;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        negative_d  = negative_q;
        zero_d      = zero_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    acc_d   = '0;
                    case (op)
                        OpSubCode: begin
                            opa_d   = a;
                            opb_d   = ~b;
                            carry_d = ~carry_in;
                        end
                        OpNegCode: begin
                            opa_d   = ~a;
                            opb_d   = '0;
                            carry_d = 1'b1;
                        end
                        default: begin
                            opa_d   = a;
                            opb_d   = b;
                            carry_d = carry_in;
                        end
                    endcase
                end
            end
            StRun: begin
                acc_d   = full_sum;
                opa_d   = opa_q >> W;
                opb_d   = opb_q >> W;
                carry_d = slice_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StDone;
                    result_d    = sat_sum;
                    carry_out_d = slice_cout;
                    overflow_d  = ovf;
                    negative_d  = sat_sum[N-1];
                    zero_d      = (sat_sum == '0);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            negative_q  <= negative_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign negative  = negative_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_radix_complement_addsub.sv
// Bench for radix_complement_addsub (N=32, W=8): directed corner cases, random ops, reset abort.
module tb_radix_complement_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out, overflow, negative, zero;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        ng;
        logic        zr;
    } exp_t;

    radix_complement_addsub #(
        .N (32),
        .W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .negative  (negative),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on the operand values.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   input logic c);
        longint sx, sy, ci, s;
        logic [32:0] u;
        exp_t e;
        sx = $signed(x);
        sy = $signed(y);
        ci = c ? 1 : 0;
        case (o)
            2'b01: begin
                s    = sx - sy - ci;
                e.co = ({1'b0, x} >= ({1'b0, y} + {32'd0, c}));
            end
            2'b10: begin
                s    = -sx;
                e.co = (x == 32'd0);
            end
            default: begin
                s    = sx + sy + ci;
                u    = {1'b0, x} + {1'b0, y} + {32'd0, c};
                e.co = u[32];
            end
        endcase
        e.ov  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.res = s[31:0];
`ifdef RADIX_COMPLEMENT_ADDSUB_SATURATE_EN
        if (e.ov) e.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        e.ng = e.res[31];
        e.zr = (e.res == 32'd0);
        return e;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input int hold, output logic [31:0] got);
        exp_t e;
        int   lat;
        e = model(o, x, y, c);
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1; op = o; a = x; b = y; carry_in = c;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; they must not affect the running op.
        in_valid = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; carry_in = 1'($urandom);
        lat = 1;
        chk("run_not_valid", out_valid, 0);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            if (!out_valid) lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("result", result, e.res);
        chk("carry_out", carry_out, e.co);
        chk("overflow", overflow, e.ov);
        chk("negative", negative, e.ng);
        chk("zero", zero, e.zr);
        got = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = $urandom; b = $urandom;
            @(posedge clk);
            #1;
            chk("hold_result", result, e.res);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("consumed_valid", out_valid, 0);
        chk("consumed_ready", in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic [1:0]  ro;
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; carry_in = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry_out, overflow, negative, zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        do_op(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, got);
`ifdef RADIX_COMPLEMENT_ADDSUB_SATURATE_EN
        chk("add_ovf_const", got, 32'h7FFF_FFFF);
`else
        chk("add_ovf_const", got, 32'h8000_0000);
`endif
        do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, got);
        chk("add_wrap_const", got, 32'h0000_0000);
        do_op(2'b01, 32'd5, 32'd7, 1'b0, 0, got);
        chk("sub_neg_const", got, 32'hFFFF_FFFE);
        do_op(2'b01, 32'd7, 32'd5, 1'b1, 0, got);
        chk("sub_borrow_const", got, 32'h0000_0001);
        do_op(2'b10, 32'h8000_0000, 32'h1234_5678, 1'b1, 0, got);
        do_op(2'b10, 32'h0000_0003, 32'h0, 1'b0, 0, got);
        chk("neg_const", got, 32'hFFFF_FFFD);
        do_op(2'b11, 32'h0000_0010, 32'h0000_0020, 1'b1, 10, got);
        chk("reserved_is_add", got, 32'h0000_0031);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            do_op(ro, $urandom, $urandom, 1'($urandom), $urandom_range(0, 2), got);
        end

        // Abort an operation mid-flight with reset.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b00; a = 32'h1111_1111; b = 32'h2222_2222; carry_in = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {carry_out, overflow, negative, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_stale", out_valid, 0);
        end
        do_op(2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, 1, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/radix_complement_addsub.md
RADIX_COMPLEMENT_ADDSUB -- requirements
Module: radix_complement_addsub

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have parameter W, default 8, digit (slice) width processed per cycle; N % W != 0 or W > N SHALL be an elaboration error; S = N/W slices.
REQ-003 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-004 Ports (name, direction, width, meaning):
  clk        in   1    rising-edge clock
  rst_n      in   1    async active-low reset
  in_valid   in   1    operation request
  in_ready   out  1    block can accept request
  op         in   2    00 ADD, 01 SUB, 10 NEG, 11 reserved (treated as ADD)
  a          in   N    operand A, two's complement
  b          in   N    operand B, two's complement
  carry_in   in   1    ADD: carry-in; SUB: borrow-in; NEG: ignored
  out_valid  out  1    result available
  out_ready  in   1    consumer accepts result
  result     out  N    result
  carry_out  out  1    carry from MSB (SUB: 1 = no borrow)
  overflow   out  1    signed overflow
  negative   out  1    result[N-1] as presented
  zero       out  1    result == 0 as presented

Function
REQ-005 ADD SHALL compute a + b + carry_in; SUB SHALL compute a + ~b + (1 - carry_in); NEG SHALL compute ~a + 1. All arithmetic is modulo 2^N.
REQ-006 FSM states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-007 Accept on the edge where in_valid && in_ready: capture op, a, b (or ~b for SUB, or ~a with 0 for NEG), initial carry; slice counter = 0; IDLE -> RUN.
REQ-008 Each RUN cycle SHALL add slice k (bits k*W+W-1 : k*W) with the registered carry, store the sum slice, and register the slice carry-out; the counter increments.
REQ-009 The edge processing slice S-1 SHALL go RUN -> DONE; out_valid is high exactly S cycles after the accept edge (S=1 when W=N).
REQ-010 overflow SHALL be carry into MSB XOR carry out of MSB for ADD/SUB; for NEG, overflow = (a == 2^(N-1)).
REQ-011 In DONE, result, carry_out, overflow, negative and zero SHALL be held stable until out_valid && out_ready; that edge goes DONE -> IDLE.
REQ-012 in_valid SHALL be ignored outside IDLE; a request cannot be accepted on the same cycle as the result is consumed.
REQ-013 The op, a, b and carry_in inputs SHALL only be sampled on the accept edge; changes during RUN/DONE have no effect.

Reset
REQ-014 On rst_n low: state = IDLE, counter = 0, result = 0, carry_out = 0, overflow = 0, negative = 0, zero = 0, out_valid = 0, in_ready = 1 immediately after rst_n rises.
REQ-015 Reset asserted in RUN or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-016 Macro RADIX_COMPLEMENT_ADDSUB_SATURATE_EN defined: when overflow = 1, result SHALL be 2^(N-1)-1 if the true sign is positive (a non-negative for ADD/SUB; always for NEG), else 2^(N-1); negative/zero reflect the saturated value; overflow remains 1.
REQ-017 Macro undefined: results wrap modulo 2^N; no saturation logic is present.

Structure
REQ-018 Package radix_complement_pkg SHALL hold op_e (ADD, SUB, NEG), state_e (IDLE, RUN, DONE) and op encoding constants.
REQ-019 Sub-module radix_digit_adder (combinational W-bit adder: a, b, cin -> sum, cout, carry into MSB) SHALL be instantiated once for the slice datapath.

Verification (N=32, W=8, S=4)
REQ-020 ADD 0x7FFFFFFF + 0x00000001, carry_in 0 -> out_valid 4 cycles after accept; result 0x80000000, overflow 1, negative 1, carry_out 0; with SATURATE_EN result 0x7FFFFFFF, negative 0.
REQ-021 ADD 0xFFFFFFFF + 0x00000001, carry_in 0 -> result 0x00000000, zero 1, carry_out 1, overflow 0.
REQ-022 SUB 5 - 7, carry_in 0 -> result 0xFFFFFFFE, carry_out 0, negative 1, overflow 0; SUB 7 - 5, carry_in 1 -> result 0x00000001, carry_out 1.
REQ-023 NEG a=0x80000000 -> result 0x80000000, overflow 1 (SATURATE_EN: 0x7FFFFFFF); NEG a=0x00000003 -> 0xFFFFFFFD, overflow 0.
REQ-024 out_ready held low 10 cycles in DONE with in_valid high and a, b toggling -> result stable, in_ready 0, no new accept; after out_ready, in_ready 1 the next cycle.
REQ-025 rst_n pulsed low during RUN slice 2 -> out_valid 0 and all outputs 0 during reset, in_ready 1 after release, no stale result emitted.
